// File: rtl/div32x16.sv
// Sequential restoring divider: 32-bit unsigned dividend / 16-bit unsigned divisor.
// One trial subtraction per clock; overflow and divide-by-zero are flagged rather than computed.
module div32x16 (
  input  logic        clk94,
  input  logic        rst94,
  input  logic        St94,
  input  logic [31:0] Dvd94,
  input  logic [15:0] Dvsr94,
  output logic [15:0] Quot94,
  output logic [15:0] Rem94,
  output logic        ovf94,
  output logic        busy94,
  output logic        done94
);

  typedef enum logic [1:0] {IDLE, CHECK, ITER, DONE} state_t;

  state_t      r_state;
  logic [32:0] r_acc;
  logic [15:0] r_d;
  logic [4:0]  r_cnt;

  logic [32:0] w_shift;
  logic [16:0] w_diff;
  logic        w_fits;
  logic [32:0] w_accNext;

  // Shift in the next dividend bit, then try to subtract the divisor from the 17-bit window.
  always_comb begin
    w_shift   = {r_acc[31:0], 1'b0};
    w_diff    = w_shift[32:16] - {1'b0, r_d};
    w_fits    = (w_shift[32:16] >= {1'b0, r_d});
    w_accNext = w_shift;
    if (w_fits) begin
      w_accNext = {w_diff, w_shift[15:1], 1'b1};
    end
  end

  always_ff @(posedge clk94 or posedge rst94) begin
    if (rst94) begin
      r_state <= IDLE;
      r_acc   <= '0;
      r_d     <= '0;
      r_cnt   <= '0;
      Quot94  <= '0;
      Rem94   <= '0;
      ovf94   <= 1'b0;
      busy94  <= 1'b0;
      done94  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          done94 <= 1'b0;
          if (St94) begin
            r_acc   <= {1'b0, Dvd94};
            r_d     <= Dvsr94;
            r_cnt   <= '0;
            busy94  <= 1'b1;
            r_state <= CHECK;
          end
        end
        CHECK: begin
          // A dividend upper half >= divisor means the quotient needs more than 16 bits.
          if ((r_d == 16'd0) || (r_acc[31:16] >= r_d)) begin
            Quot94  <= 16'hFFFF;
            Rem94   <= 16'h0000;
            ovf94   <= 1'b1;
            done94  <= 1'b1;
            r_state <= DONE;
          end else begin
            r_state <= ITER;
          end
        end
        ITER: begin
          r_acc <= w_accNext;
          r_cnt <= r_cnt + 5'd1;
          if (r_cnt == 5'd15) begin
            Quot94  <= w_accNext[15:0];
            Rem94   <= w_accNext[31:16];
            ovf94   <= 1'b0;
            done94  <= 1'b1;
            r_state <= DONE;
          end
        end
        DONE: begin
          done94  <= 1'b0;
          busy94  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          done94  <= 1'b0;
          busy94  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule
